// File: rtl/ide_chan_sched.sv
// Round-robin scheduler sharing one host management port between two IDE channels.
// Offers one pending channel request at a time, then routes host strobes to it until release or watchdog expiry.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// ST_IDLE    | no offer outstanding; arbitrate between pending channels
// ST_OFFER   | request of channel sel shown to host, waiting for host_ack
// ST_SERVICE | host owns channel sel; strobes routed there, watchdog running
module ide_chan_sched #(
    parameter int WDOG_BITS = 24
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [2:0]  ch_request0,
    input  logic [2:0]  ch_request1,
    output logic [3:0]  ch_mgmt_address,
    output logic [15:0] ch_mgmt_writedata,
    output logic [1:0]  ch_mgmt_write,
    output logic [1:0]  ch_mgmt_read,
    input  logic [15:0] ch_mgmt_readdata0,
    input  logic [15:0] ch_mgmt_readdata1,
    output logic        host_req_valid,
    output logic        host_req_chan,
    output logic [2:0]  host_req_code,
    input  logic        host_ack,
    input  logic        host_done,
    input  logic        host_cfg_chan,
    input  logic [3:0]  host_address,
    input  logic        host_write,
    input  logic        host_read,
    input  logic [15:0] host_writedata,
    output logic [15:0] host_readdata,
    output logic        busy,
    output logic        wdog_err
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_OFFER   = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

    localparam logic [WDOG_BITS-1:0] WDOG_LOAD = '1;
    localparam logic [WDOG_BITS-1:0] WDOG_ONE  = WDOG_BITS'(1);
    localparam logic [3:0]           CFG_ADDR  = 4'd6;

    state_t               state_q, state_d;
    logic                 sel_q, sel_d;
    logic                 rr_q, rr_d;
    logic [2:0]           code_q, code_d;
    logic                 valid_q, valid_d;
    logic [WDOG_BITS-1:0] wdog_q, wdog_d;
    logic                 wdog_err_q, wdog_err_d;

    logic                 pend0, pend1;
    logic                 choice;
    logic [2:0]           sel_req;
    logic                 host_strobe;

    assign pend0       = |ch_request0;
    assign pend1       = |ch_request1;
    assign choice      = (pend0 && pend1) ? rr_q : pend1;
    assign sel_req     = sel_q ? ch_request1 : ch_request0;
    assign host_strobe = host_write | host_read;

    // Watchdog is a down-counter holding the idle cycles still allowed; expiry on the last one.
    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        rr_d       = rr_q;
        code_d     = code_q;
        valid_d    = valid_q;
        wdog_d     = wdog_q;
        wdog_err_d = wdog_err_q;
        case (state_q)
            ST_IDLE: begin
                if (pend0 || pend1) begin
                    sel_d   = choice;
                    code_d  = choice ? ch_request1 : ch_request0;
                    valid_d = 1'b1;
                    state_d = ST_OFFER;
                end
            end
            ST_OFFER: begin
                if (host_ack) begin
                    state_d = ST_SERVICE;
                    valid_d = 1'b0;
                    wdog_d  = WDOG_LOAD;
                end else if (sel_req == 3'd0) begin
                    state_d = ST_IDLE;
                    valid_d = 1'b0;
                end else if (sel_req != code_q) begin
                    code_d = sel_req;
                end
            end
            ST_SERVICE: begin
                if (host_done) begin
                    state_d = ST_IDLE;
                    rr_d    = ~sel_q;
                end else if (host_strobe) begin
                    wdog_d = WDOG_LOAD;
                end else if (wdog_q <= WDOG_ONE) begin
                    state_d    = ST_IDLE;
                    rr_d       = ~sel_q;
                    wdog_err_d = 1'b1;
                end else begin
                    wdog_d = wdog_q - WDOG_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            sel_q      <= 1'b0;
            rr_q       <= 1'b0;
            code_q     <= 3'd0;
            valid_q    <= 1'b0;
            wdog_q     <= '0;
            wdog_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            rr_q       <= rr_d;
            code_q     <= code_d;
            valid_q    <= valid_d;
            wdog_q     <= wdog_d;
            wdog_err_q <= wdog_err_d;
        end
    end

    // Strobes are combinational and also masked by rst_n so they drop on the reset edge itself.
    always_comb begin
        ch_mgmt_write = 2'b00;
        ch_mgmt_read  = 2'b00;
        host_readdata = 16'h0000;
        if (rst_n) begin
            if (state_q == ST_SERVICE) begin
                ch_mgmt_write[sel_q] = host_write;
                ch_mgmt_read[sel_q]  = host_read;
                host_readdata        = sel_q ? ch_mgmt_readdata1 : ch_mgmt_readdata0;
            end else if (host_write && (host_address == CFG_ADDR)) begin
                ch_mgmt_write[host_cfg_chan] = 1'b1;
            end
        end
    end

    assign ch_mgmt_address   = host_address;
    assign ch_mgmt_writedata = host_writedata;
    assign host_req_valid    = valid_q;
    assign host_req_chan     = sel_q;
    assign host_req_code     = code_q;
    assign busy              = (state_q == ST_SERVICE);
    assign wdog_err          = wdog_err_q;

endmodule

// File: tb/tb_ide_chan_sched.sv
// Self-checking bench for ide_chan_sched: vector table for strobe routing, scripted
// sequences for arbitration, offer tracking, watchdog and reset.
module tb_ide_chan_sched;

    logic        clk;
    logic        rst_n;
    logic [2:0]  ch_request0, ch_request1;
    logic [3:0]  ch_mgmt_address;
    logic [15:0] ch_mgmt_writedata;
    logic [1:0]  ch_mgmt_write, ch_mgmt_read;
    logic [15:0] ch_mgmt_readdata0, ch_mgmt_readdata1;
    logic        host_req_valid, host_req_chan;
    logic [2:0]  host_req_code;
    logic        host_ack, host_done, host_cfg_chan;
    logic [3:0]  host_address;
    logic        host_write, host_read;
    logic [15:0] host_writedata, host_readdata;
    logic        busy, wdog_err;

    int n_pass  = 0;
    int n_total = 0;

    ide_chan_sched #(.WDOG_BITS(4)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .ch_request0       (ch_request0),
        .ch_request1       (ch_request1),
        .ch_mgmt_address   (ch_mgmt_address),
        .ch_mgmt_writedata (ch_mgmt_writedata),
        .ch_mgmt_write     (ch_mgmt_write),
        .ch_mgmt_read      (ch_mgmt_read),
        .ch_mgmt_readdata0 (ch_mgmt_readdata0),
        .ch_mgmt_readdata1 (ch_mgmt_readdata1),
        .host_req_valid    (host_req_valid),
        .host_req_chan     (host_req_chan),
        .host_req_code     (host_req_code),
        .host_ack          (host_ack),
        .host_done         (host_done),
        .host_cfg_chan     (host_cfg_chan),
        .host_address      (host_address),
        .host_write        (host_write),
        .host_read         (host_read),
        .host_writedata    (host_writedata),
        .host_readdata     (host_readdata),
        .busy              (busy),
        .wdog_err          (wdog_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Channel models: registered read data, one cycle after the address.
    always @(posedge clk) begin
        ch_mgmt_readdata0 <= 16'h1000 | {12'h000, ch_mgmt_address};
        ch_mgmt_readdata1 <= 16'h2000 | {12'h000, ch_mgmt_address};
    end

    typedef struct {
        logic        wr;
        logic        rd;
        logic [3:0]  addr;
        logic [15:0] wdata;
        logic        cfg;
        logic [1:0]  exp_wr;
        logic [1:0]  exp_rd;
        logic [15:0] exp_rdata;
    } vec_t;

    vec_t        vecs[9];
    logic [15:0] rd_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_host();
        host_ack = 0; host_done = 0; host_write = 0; host_read = 0;
        host_address = 0; host_writedata = 0; host_cfg_chan = 0;
    endtask

    task automatic apply_vec(input vec_t v, input string tag);
        logic [15:0] e;
        host_write = v.wr; host_read = v.rd; host_address = v.addr;
        host_writedata = v.wdata; host_cfg_chan = v.cfg;
        @(negedge clk);
        chk({tag, "_strobes"}, {ch_mgmt_write, ch_mgmt_read}, {v.exp_wr, v.exp_rd});
        chk({tag, "_addr_data"}, {ch_mgmt_address, ch_mgmt_writedata}, {v.addr, v.wdata});
        if (rd_q.size() > 0) begin
            e = rd_q.pop_front();
            chk({tag, "_readdata"}, host_readdata, e);
        end
        if (v.rd) rd_q.push_back(v.exp_rdata);
        tick();
    endtask

    task automatic drain(input string tag);
        logic [15:0] e;
        clear_host();
        @(negedge clk);
        while (rd_q.size() > 0) begin
            e = rd_q.pop_front();
            chk({tag, "_readdata"}, host_readdata, e);
        end
        tick();
    endtask

    task automatic check_offer(input string tag, input logic chan, input logic [2:0] code);
        chk(tag, {host_req_valid, host_req_chan, host_req_code, busy}, {1'b1, chan, code, 1'b0});
    endtask

    task automatic ack();
        host_ack = 1; tick(); host_ack = 0;
    endtask

    task automatic done();
        host_done = 1; tick(); host_done = 0;
    endtask

    task automatic count_busy(input string tag, input int exp);
        int cnt = 0;
        while (busy && cnt < 40) begin
            tick();
            cnt++;
        end
        chk(tag, cnt, exp);
    endtask

    initial begin
        // SERVICE on channel 1
        vecs[0] = '{wr:1, rd:0, addr:4'd5, wdata:16'h0450, cfg:0, exp_wr:2'b10, exp_rd:2'b00, exp_rdata:16'h0000};
        vecs[1] = '{wr:0, rd:1, addr:4'd3, wdata:16'h1234, cfg:0, exp_wr:2'b00, exp_rd:2'b10, exp_rdata:16'h2003};
        vecs[2] = '{wr:1, rd:0, addr:4'd6, wdata:16'hBEEF, cfg:0, exp_wr:2'b10, exp_rd:2'b00, exp_rdata:16'h0000};
        vecs[3] = '{wr:0, rd:1, addr:4'd9, wdata:16'h0000, cfg:1, exp_wr:2'b00, exp_rd:2'b10, exp_rdata:16'h2009};
        // IDLE, nothing pending
        vecs[4] = '{wr:1, rd:0, addr:4'd6, wdata:16'h0001, cfg:1, exp_wr:2'b10, exp_rd:2'b00, exp_rdata:16'h0000};
        vecs[5] = '{wr:1, rd:0, addr:4'd6, wdata:16'h0002, cfg:0, exp_wr:2'b01, exp_rd:2'b00, exp_rdata:16'h0000};
        vecs[6] = '{wr:1, rd:0, addr:4'd5, wdata:16'h0003, cfg:1, exp_wr:2'b00, exp_rd:2'b00, exp_rdata:16'h0000};
        vecs[7] = '{wr:0, rd:1, addr:4'd6, wdata:16'h0000, cfg:1, exp_wr:2'b00, exp_rd:2'b00, exp_rdata:16'h0000};
        vecs[8] = '{wr:0, rd:1, addr:4'd2, wdata:16'h0000, cfg:0, exp_wr:2'b00, exp_rd:2'b00, exp_rdata:16'h0000};

        rst_n = 0; ch_request0 = 0; ch_request1 = 0;
        clear_host();
        repeat (3) tick();
        @(negedge clk);
        chk("reset_outputs",
            {host_req_valid, host_req_chan, host_req_code, busy, wdog_err, ch_mgmt_write, ch_mgmt_read, host_readdata},
            '0);
        rst_n = 1;
        tick();

        // Single request on channel 1, then routed strobes
        ch_request1 = 3'b100;
        tick();
        check_offer("single_offer", 1'b1, 3'b100);
        ack();
        chk("single_ack", {busy, host_req_valid, host_req_chan}, {1'b1, 1'b0, 1'b1});
        for (int i = 0; i < 4; i++) apply_vec(vecs[i], $sformatf("svc_v%0d", i));
        drain("svc_drain");

        // Release with a coincident write; channel 1 still pending is re-offered one cycle later
        host_done = 1; host_write = 1; host_address = 4'd2;
        @(negedge clk);
        chk("done_write_fwd", ch_mgmt_write, 2'b10);
        tick();
        clear_host();
        chk("done_idle", {busy, host_req_valid}, 2'b00);
        tick();
        check_offer("reoffer_ch1", 1'b1, 3'b100);
        ch_request1 = 3'b000;
        tick();
        chk("drop_ch1", {host_req_valid, busy}, 2'b00);

        for (int i = 4; i < 9; i++) apply_vec(vecs[i], $sformatf("idle_v%0d", i));
        drain("idle_drain");

        // Round-robin from reset with both channels pending
        rst_n = 0; ch_request0 = 3'b101; ch_request1 = 3'b101;
        tick(); tick();
        rst_n = 1;
        tick();
        check_offer("rr_first", 1'b0, 3'b101);
        ack(); done(); tick();
        check_offer("rr_second", 1'b1, 3'b101);
        ack(); done(); tick();
        check_offer("rr_third", 1'b0, 3'b101);

        // Watchdog: no strobes after ack
        ack();
        chk("wdog_pre", {busy, wdog_err}, 2'b10);
        count_busy("wdog_busy_cycles", 15);
        chk("wdog_err_set", wdog_err, 1'b1);
        tick();
        check_offer("wdog_rr_other", 1'b1, 3'b101);

        // Watchdog restart by a strobe on the 10th service cycle
        ack();
        repeat (9) tick();
        host_write = 1; host_address = 4'd1;
        @(negedge clk);
        chk("wdog_strobe_fwd", ch_mgmt_write, 2'b10);
        tick();
        clear_host();
        count_busy("wdog_restart_cycles", 15);
        chk("wdog_err_sticky", wdog_err, 1'b1);

        // Code change and drop during OFFER
        ch_request0 = 3'b100; ch_request1 = 3'b000;
        tick();
        check_offer("chg_offer", 1'b0, 3'b100);
        ch_request0 = 3'b110;
        tick();
        check_offer("chg_code", 1'b0, 3'b110);
        ch_request0 = 3'b000;
        tick();
        chk("chg_drop", {host_req_valid, busy}, 2'b00);
        ch_request0 = 3'b100;
        tick();
        check_offer("ackdrop_offer", 1'b0, 3'b100);
        ch_request0 = 3'b000;
        ack();
        chk("ackdrop_busy", {busy, host_req_valid}, 2'b10);
        done();
        chk("ackdrop_release", busy, 1'b0);

        // Reset during SERVICE with a write in flight
        ch_request1 = 3'b011;
        tick();
        check_offer("rst_offer", 1'b1, 3'b011);
        ack();
        host_write = 1; host_address = 4'd5; host_writedata = 16'h00AA;
        rst_n = 0;
        @(negedge clk);
        chk("rst_strobe_drop", ch_mgmt_write, 2'b00);
        tick();
        chk("rst_all_zero",
            {host_req_valid, host_req_chan, host_req_code, busy, wdog_err, ch_mgmt_write, ch_mgmt_read, host_readdata},
            '0);
        rst_n = 1;
        clear_host();
        tick();
        check_offer("rst_reoffer", 1'b1, 3'b011);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
